// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-side (req0) and D-side (req1) miss paths.
// Latches the winner's command, strobes the L2 for one cycle, and returns the response or a timeout error.
module l2_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int L1_BLOCK_SIZE = 16,
  parameter int TIMEOUT       = 1023
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [ADDR_WIDTH-1:0]                       req0_addr,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    req0_wdata,
  input  logic                                        req0_read,
  input  logic                                        req0_write,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    req0_rdata,
  output logic                                        req0_ready,
  output logic                                        req0_err,
  input  logic [ADDR_WIDTH-1:0]                       req1_addr,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    req1_wdata,
  input  logic                                        req1_read,
  input  logic                                        req1_write,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    req1_rdata,
  output logic                                        req1_ready,
  output logic                                        req1_err,
  output logic [ADDR_WIDTH-1:0]                       l2_addr,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    l2_wdata,
  output logic                                        l2_read,
  output logic                                        l2_write,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    l2_rdata,
  input  logic                                        l2_ready,
  output logic                                        busy,
  output logic                                        grant
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic              last_grant, last_grant_n;
  logic              grant_n;
  logic              op_write, op_write_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] l2_addr_n;
  block_t            l2_wdata_n;
  logic              l2_read_n, l2_write_n;
  block_t            rdata0_n, rdata1_n, resp_data;
  logic              ready0_n, ready1_n, err0_n, err1_n;
  logic              busy_n;
  logic              pend0, pend1, win;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_n      = grant;
    op_write_n   = op_write;
    cnt_n        = cnt;
    l2_addr_n    = l2_addr;
    l2_wdata_n   = l2_wdata;
    l2_read_n    = 1'b0;
    l2_write_n   = 1'b0;
    rdata0_n     = '0;
    rdata1_n     = '0;
    ready0_n     = 1'b0;
    ready1_n     = 1'b0;
    err0_n       = 1'b0;
    err1_n       = 1'b0;
    resp_data    = '0;
    pend0        = req0_read | req0_write;
    pend1        = req1_read | req1_write;
    // On a tie the requester that was not served last wins.
    win          = (pend0 && pend1) ? ~last_grant : pend1;

    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          state_n    = ISSUE;
          grant_n    = win;
          l2_addr_n  = win ? req1_addr  : req0_addr;
          l2_wdata_n = win ? req1_wdata : req0_wdata;
          op_write_n = win ? req1_write : req0_write;
          l2_write_n = op_write_n;
          l2_read_n  = ~op_write_n;
          cnt_n      = CNT_W'(TIMEOUT);
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (l2_ready || (cnt == '0)) begin
          state_n      = RESP;
          last_grant_n = grant;
          resp_data    = (l2_ready && !op_write) ? l2_rdata : '0;
          if (grant) begin
            ready1_n = 1'b1;
            err1_n   = ~l2_ready;
            rdata1_n = resp_data;
          end else begin
            ready0_n = 1'b1;
            err0_n   = ~l2_ready;
            rdata0_n = resp_data;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      op_write   <= 1'b0;
      cnt        <= '0;
      l2_addr    <= '0;
      l2_wdata   <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      op_write   <= op_write_n;
      cnt        <= cnt_n;
      l2_addr    <= l2_addr_n;
      l2_wdata   <= l2_wdata_n;
      l2_read    <= l2_read_n;
      l2_write   <= l2_write_n;
      req0_rdata <= rdata0_n;
      req1_rdata <= rdata1_n;
      req0_ready <= ready0_n;
      req1_ready <= ready1_n;
      req0_err   <= err0_n;
      req1_err   <= err1_n;
      busy       <= busy_n;
    end
  end

endmodule
